// File: rtl/stream_max_finder.sv
// stream_max_finder
// Walks a burst of COUNT signed samples and reports the largest one together
// with the index of its first occurrence. The signed "x > y" decision is made
// by an external comparator: this block presents the new sample on cmp_x and
// the running maximum on cmp_y, holds them for SETTLE cycles, and then reads
// the comparator's zero/overflow/negative flags.
module stream_max_finder #(
   parameter int WIDTH  = 4,
   parameter int COUNT  = 8,
   parameter int SETTLE = 2,
   parameter int IDXW   = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic [WIDTH-1:0] cmp_x,
   output logic [WIDTH-1:0] cmp_y,
   input  logic             cmp_z,
   input  logic             cmp_v,
   input  logic             cmp_n,
   output logic             busy,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_max,
   output logic [IDXW-1:0]  out_idx
);

   localparam int SCW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [IDXW-1:0] LAST_IDX    = IDXW'(COUNT - 1);
   localparam logic [SCW-1:0]  LAST_SETTLE = SCW'(SETTLE - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT_IN,
      ST_SETTLE,
      ST_DECIDE,
      ST_DONE
   } state_t;

   state_t           state;
   logic [IDXW-1:0]  cnt;
   logic [SCW-1:0]   settle_cnt;
   logic [WIDTH-1:0] max_val;
   logic [IDXW-1:0]  max_idx;
   logic             greater;
   logic [WIDTH-1:0] next_max;
   logic [IDXW-1:0]  next_idx;

   // Signed x > y from the flags of x - y: nonzero and N equal to V.
   // Only strictly greater moves the maximum, so ties keep the earlier index.
   always_comb begin
      greater  = !cmp_z && !(cmp_n ^ cmp_v);
      next_max = greater ? cmp_x : max_val;
      next_idx = greater ? cnt : max_idx;
   end

   // Burst controller; every output is a register updated on its state transition.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         settle_cnt <= '0;
         max_val    <= '0;
         max_idx    <= '0;
         cmp_x      <= '0;
         cmp_y      <= '0;
         in_ready   <= 1'b0;
         busy       <= 1'b0;
         out_valid  <= 1'b0;
         out_max    <= '0;
         out_idx    <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state    <= ST_WAIT_IN;
                  cnt      <= '0;
                  in_ready <= 1'b1;
                  busy     <= 1'b1;
               end
            end
            ST_WAIT_IN: begin
               if (in_valid && in_ready) begin
                  if (cnt == '0) begin
                     max_val <= in_data;
                     max_idx <= '0;
                     if (COUNT == 1) begin
                        state     <= ST_DONE;
                        in_ready  <= 1'b0;
                        out_valid <= 1'b1;
                        out_max   <= in_data;
                        out_idx   <= '0;
                     end else begin
                        cnt <= IDXW'(1);
                     end
                  end else begin
                     cmp_x      <= in_data;
                     cmp_y      <= max_val;
                     settle_cnt <= '0;
                     in_ready   <= 1'b0;
                     state      <= ST_SETTLE;
                  end
               end
            end
            ST_SETTLE: begin
               if (settle_cnt == LAST_SETTLE) begin
                  state <= ST_DECIDE;
               end else begin
                  settle_cnt <= settle_cnt + SCW'(1);
               end
            end
            ST_DECIDE: begin
               max_val <= next_max;
               max_idx <= next_idx;
               cnt     <= cnt + IDXW'(1);
               if (cnt == LAST_IDX) begin
                  state     <= ST_DONE;
                  out_valid <= 1'b1;
                  out_max   <= next_max;
                  out_idx   <= next_idx;
               end else begin
                  state    <= ST_WAIT_IN;
                  in_ready <= 1'b1;
               end
            end
            ST_DONE: begin
               out_valid <= 1'b0;
               busy      <= 1'b0;
               state     <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
